// File: rtl/reorder_buffer_if.sv
// Dispatcher / execution / commit bus of the reorder buffer.
interface reorder_buffer_if #(
    parameter int unsigned RoB_WIDTH = 3
);
    logic                 alloc_en;
    logic [4:0]           alloc_rd;
    logic                 alloc_is_branch;
    logic                 alloc_ready;
    logic [RoB_WIDTH-1:0] alloc_index;

    logic                 wb_en;
    logic [RoB_WIDTH-1:0] wb_index;
    logic [31:0]          wb_data;
    logic                 wb_mispredict;
    logic [31:0]          wb_target;

    logic                 rf_update_en;
    logic [4:0]           rf_update_reg;
    logic [RoB_WIDTH-1:0] rf_update_index;
    logic [31:0]          rf_update_data;
    logic                 flush_out;
    logic [31:0]          flush_pc;

    // Pipeline side: dispatches, writes back, consumes commits and flushes.
    modport master (
        output alloc_en, alloc_rd, alloc_is_branch,
        output wb_en, wb_index, wb_data, wb_mispredict, wb_target,
        input  alloc_ready, alloc_index,
        input  rf_update_en, rf_update_reg, rf_update_index, rf_update_data,
        input  flush_out, flush_pc
    );

    // Reorder buffer side.
    modport slave (
        input  alloc_en, alloc_rd, alloc_is_branch,
        input  wb_en, wb_index, wb_data, wb_mispredict, wb_target,
        output alloc_ready, alloc_index,
        output rf_update_en, rf_update_reg, rf_update_index, rf_update_data,
        output flush_out, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates at tail, completes by index,
// retires from head into the register file and raises flush on a mispredict.
module reorder_buffer #(
    parameter int unsigned RoB_WIDTH = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    reorder_buffer_if.slave  bus
);
    localparam int unsigned RoB_SIZE = 1 << RoB_WIDTH;
    localparam int unsigned CNT_W    = RoB_WIDTH + 1;

    logic [RoB_WIDTH-1:0] head;
    logic [RoB_WIDTH-1:0] tail;
    logic [CNT_W-1:0]     count;
    logic [RoB_SIZE-1:0]  busy;
    logic [RoB_SIZE-1:0]  ready;

    logic [4:0]           rd_mem     [RoB_SIZE];
    logic [RoB_SIZE-1:0]  br_mem;
    logic [RoB_SIZE-1:0]  mis_mem;
    logic [31:0]          data_mem   [RoB_SIZE];
    logic [31:0]          target_mem [RoB_SIZE];

    logic                 upd_en;
    logic [4:0]           upd_reg;
    logic [RoB_WIDTH-1:0] upd_index;
    logic [31:0]          upd_data;
    logic                 flush;
    logic [31:0]          flush_target;

    logic                 full_c;
    logic                 alloc_ok_c;
    logic                 wb_ok_c;
    logic                 commit_c;
    logic                 flush_c;

    // Per-cycle decisions, all from registered state; the flush cycle blocks everything.
    always_comb begin
        full_c     = (count == CNT_W'(RoB_SIZE));
        alloc_ok_c = bus.alloc_en && !full_c && !flush;
        wb_ok_c    = bus.wb_en && busy[bus.wb_index] && !flush;
        commit_c   = !flush && busy[head] && ready[head];
        flush_c    = commit_c && br_mem[head] && mis_mem[head];
    end

    // Entry payload; validity is tracked by busy/ready so no reset is needed here.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (alloc_ok_c && !flush_c) begin
                rd_mem[tail]  <= bus.alloc_rd;
                br_mem[tail]  <= bus.alloc_is_branch;
                mis_mem[tail] <= 1'b0;
            end
            if (wb_ok_c) begin
                data_mem[bus.wb_index]   <= bus.wb_data;
                mis_mem[bus.wb_index]    <= bus.wb_mispredict;
                target_mem[bus.wb_index] <= bus.wb_target;
            end
        end
    end

    // Pointers, occupancy, entry status and registered commit/flush outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            upd_en       <= 1'b0;
            upd_reg      <= '0;
            upd_index    <= '0;
            upd_data     <= '0;
            flush        <= 1'b0;
            flush_target <= '0;
        end else if (rdy_in) begin
            upd_en <= 1'b0;
            flush  <= 1'b0;
            if (commit_c) begin
                upd_en    <= (rd_mem[head] != 5'd0);
                upd_reg   <= rd_mem[head];
                upd_index <= head;
                upd_data  <= data_mem[head];
            end
            if (flush_c) begin
                flush        <= 1'b1;
                flush_target <= target_mem[head];
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                busy         <= '0;
                ready        <= '0;
            end else begin
                if (wb_ok_c) begin
                    ready[bus.wb_index] <= 1'b1;
                end
                if (commit_c) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + RoB_WIDTH'(1);
                end
                if (alloc_ok_c) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + RoB_WIDTH'(1);
                end
                count <= count + CNT_W'(alloc_ok_c) - CNT_W'(commit_c);
            end
        end
    end

    assign bus.alloc_ready     = !full_c;
    assign bus.alloc_index     = tail;
    assign bus.rf_update_en    = upd_en;
    assign bus.rf_update_reg   = upd_reg;
    assign bus.rf_update_index = upd_index;
    assign bus.rf_update_data  = upd_data;
    assign bus.flush_out       = flush;
    assign bus.flush_pc        = flush_target;
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a queue-based model.
module tb_reorder_buffer;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    always #5 clk_in = ~clk_in;

    reorder_buffer_if #(.RoB_WIDTH(3)) bus ();

    reorder_buffer #(.RoB_WIDTH(3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    typedef struct {
        int          idx;
        logic [4:0]  rd;
        bit          br;
        bit          done;
        bit          mis;
        logic [31:0] data;
        logic [31:0] tgt;
    } ent_t;

    // Model: program-order list of live instructions plus expected registered outputs.
    ent_t        q[$];
    int          m_tail;
    bit          m_flush;
    bit          m_en;
    logic [4:0]  m_reg;
    int          m_idx;
    logic [31:0] m_data;
    logic [31:0] m_pc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail  = 0;
        m_flush = 0;
        m_en    = 0;
        m_reg   = '0;
        m_idx   = 0;
        m_data  = '0;
        m_pc    = '0;
    endtask

    task automatic model_cycle(input bit rdy, input bit ae, input logic [4:0] rd, input bit br,
                               input bit we, input logic [2:0] wi, input logic [31:0] wd,
                               input bit wm, input logic [31:0] wt);
        bit   nf;
        bit   ne;
        bit   com;
        bit   alloc_ok;
        int   sz;
        ent_t e;
        ent_t n;
        if (!rdy) return;
        nf = 0;
        ne = 0;
        if (!m_flush) begin
            sz       = q.size();
            com      = (sz > 0) && q[0].done;
            alloc_ok = ae && (sz != 8);
            if (com) e = q[0];
            if (we) begin
                foreach (q[i]) begin
                    if (q[i].idx == int'(wi)) begin
                        q[i].done = 1;
                        q[i].data = wd;
                        q[i].mis  = wm;
                        q[i].tgt  = wt;
                    end
                end
            end
            if (com) begin
                q.delete(0);
                ne     = (e.rd != 5'd0);
                m_reg  = e.rd;
                m_idx  = e.idx;
                m_data = e.data;
                if (e.br && e.mis) begin
                    nf   = 1;
                    m_pc = e.tgt;
                    q.delete();
                    m_tail   = 0;
                    alloc_ok = 0;
                end
            end
            if (alloc_ok) begin
                n.idx  = m_tail;
                n.rd   = rd;
                n.br   = br;
                n.done = 0;
                n.mis  = 0;
                n.data = '0;
                n.tgt  = '0;
                q.push_back(n);
                m_tail = (m_tail + 1) % 8;
            end
        end
        m_flush = nf;
        m_en    = ne;
    endtask

    task automatic check_outputs();
        check("rf_update_en", bus.rf_update_en, m_en);
        if (m_en) begin
            check("rf_update_reg", bus.rf_update_reg, m_reg);
            check("rf_update_index", bus.rf_update_index, m_idx);
            check("rf_update_data", bus.rf_update_data, m_data);
        end
        check("flush_out", bus.flush_out, m_flush);
        if (m_flush) check("flush_pc", bus.flush_pc, m_pc);
    endtask

    // One clock: drive inputs, check combinational outputs, then registered outputs after the edge.
    task automatic step(input bit rdy, input bit ae, input logic [4:0] rd, input bit br,
                        input bit we, input logic [2:0] wi, input logic [31:0] wd,
                        input bit wm, input logic [31:0] wt);
        rdy_in              = rdy;
        bus.alloc_en        = ae;
        bus.alloc_rd        = rd;
        bus.alloc_is_branch = br;
        bus.wb_en           = we;
        bus.wb_index        = wi;
        bus.wb_data         = wd;
        bus.wb_mispredict   = wm;
        bus.wb_target       = wt;
        #1;
        check("alloc_ready", bus.alloc_ready, q.size() != 8);
        check("alloc_index", bus.alloc_index, m_tail);
        model_cycle(rdy, ae, rd, br, we, wi, wd, wm, wt);
        @(posedge clk_in);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 5'd0, 0, 0, 3'd0, 32'd0, 0, 32'd0);
    endtask

    task automatic alloc(input logic [4:0] rd, input bit br);
        step(1, 1, rd, br, 0, 3'd0, 32'd0, 0, 32'd0);
    endtask

    task automatic wb(input logic [2:0] wi, input logic [31:0] wd, input bit wm, input logic [31:0] wt);
        step(1, 0, 5'd0, 0, 1, wi, wd, wm, wt);
    endtask

    // Reset with rdy_in low to show reset wins over the freeze.
    task automatic do_reset();
        rst_in       = 1'b1;
        rdy_in       = 1'b0;
        bus.alloc_en = 1'b0;
        bus.wb_en    = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        model_reset();
        check("rst_rf_update_en", bus.rf_update_en, 32'd0);
        check("rst_rf_update_reg", bus.rf_update_reg, 32'd0);
        check("rst_rf_update_index", bus.rf_update_index, 32'd0);
        check("rst_rf_update_data", bus.rf_update_data, 32'd0);
        check("rst_flush_out", bus.flush_out, 32'd0);
        check("rst_flush_pc", bus.flush_pc, 32'd0);
        check("rst_alloc_ready", bus.alloc_ready, 32'd1);
        check("rst_alloc_index", bus.alloc_index, 32'd0);
    endtask

    initial begin
        int          wi;
        bit          rdy;
        bit          ae;
        bit          we;
        bit          br;
        logic [4:0]  rd;

        rst_in              = 1'b1;
        rdy_in              = 1'b0;
        bus.alloc_en        = 1'b0;
        bus.alloc_rd        = '0;
        bus.alloc_is_branch = 1'b0;
        bus.wb_en           = 1'b0;
        bus.wb_index        = '0;
        bus.wb_data         = '0;
        bus.wb_mispredict   = 1'b0;
        bus.wb_target       = '0;
        do_reset();

        // Single alloc / writeback / commit.
        alloc(5'd5, 0);
        wb(3'd0, 32'h1234, 0, 32'd0);
        idle(1);
        check("t1_en", bus.rf_update_en, 32'd1);
        check("t1_reg", bus.rf_update_reg, 32'd5);
        check("t1_data", bus.rf_update_data, 32'h1234);
        check("t1_empty_index", bus.alloc_index, 32'd1);

        // Fill to full, ninth alloc dropped, commit frees a slot.
        do_reset();
        for (int i = 0; i < 9; i++) alloc(5'(i + 1), 0);
        check("t2_full", bus.alloc_ready, 32'd0);
        wb(3'd0, 32'hAAAA_0000, 0, 32'd0);
        idle(1);
        check("t2_freed", bus.alloc_ready, 32'd1);
        check("t2_commit_reg", bus.rf_update_reg, 32'd1);

        // Out-of-order writeback, in-order commit.
        do_reset();
        for (int i = 0; i < 3; i++) alloc(5'(i + 10), 0);
        wb(3'd2, 32'h22, 0, 32'd0);
        wb(3'd1, 32'h11, 0, 32'd0);
        wb(3'd0, 32'h00, 0, 32'd0);
        idle(4);

        // Mispredicted branch at head flushes younger work.
        do_reset();
        alloc(5'd0, 1);
        alloc(5'd7, 0);
        wb(3'd1, 32'h77, 0, 32'd0);
        wb(3'd0, 32'h4, 1, 32'h100);
        idle(1);
        check("t4_flush", bus.flush_out, 32'd1);
        check("t4_pc", bus.flush_pc, 32'h100);
        check("t4_en", bus.rf_update_en, 32'd0);
        step(1, 1, 5'd3, 0, 1, 3'd1, 32'h9, 0, 32'd0);
        check("t4_flush_drop", bus.flush_out, 32'd0);
        check("t4_no_commit", bus.rf_update_en, 32'd0);
        check("t4_index", bus.alloc_index, 32'd0);
        idle(2);

        // Wrap-around through ten alloc/commit pairs.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            alloc((i % 2) ? 5'd0 : 5'(i + 1), 0);
            wb(3'(i % 8), 32'(i * 3), 0, 32'd0);
            idle(1);
        end
        check("t5_wrap_index", bus.alloc_index, 32'd2);

        // Freeze holds a ready head until rdy_in returns.
        do_reset();
        alloc(5'd9, 0);
        wb(3'd0, 32'hBEEF, 0, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 5'd1, 0, 0, 3'd0, 32'd0, 0, 32'd0);
        check("t6_held", bus.rf_update_en, 32'd0);
        idle(1);
        check("t6_commit", bus.rf_update_en, 32'd1);
        check("t6_data", bus.rf_update_data, 32'hBEEF);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (($urandom % 300) == 0) begin
                do_reset();
            end else begin
                rdy = ($urandom % 8) != 0;
                ae  = ($urandom % 3) != 0;
                we  = ($urandom % 4) != 0;
                br  = ($urandom % 4) == 0;
                rd  = 5'($urandom % 4 == 0 ? 0 : $urandom);
                if (q.size() > 0 && ($urandom % 5) != 0)
                    wi = q[$urandom_range(q.size() - 1, 0)].idx;
                else
                    wi = int'($urandom % 8);
                step(rdy, ae, rd, br, we, 3'(wi), $urandom, ($urandom % 6) == 0, $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
